// File: rtl/dmux_channel_capture.sv
// Sink for the 1-to-16 demux bus: per-channel rising-edge counters, last one-hot hold, sticky multi-hot error.
// Latency: 2 edges Y -> hold/last_ch/valid/err, 3 edges Y -> rd_cnt, 1 edge rd_sel -> rd_cnt.
// Backpressure: none; a new Y sample is accepted every cycle.
module dmux_channel_capture #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      Y,
    input  logic             clr,
    input  logic [3:0]       rd_sel,
    output logic [15:0]      hold,
    output logic [3:0]       last_ch,
    output logic             valid,
    output logic             err,
    output logic [CNT_W-1:0] rd_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [15:0]      y_q;
    logic [15:0]      y_prev;
    logic [15:0]      rise;
    logic [4:0]       pop;
    logic [3:0]       enc;
    logic [CNT_W-1:0] cnt [16];

    always_comb begin
        rise = y_q & ~y_prev;
        pop  = '0;
        enc  = '0;
        for (int i = 0; i < 16; i++) begin
            pop = pop + 5'(y_q[i]);
            if (y_q[i]) enc = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            y_prev  <= '0;
            hold    <= '0;
            last_ch <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
            rd_cnt  <= '0;
            for (int i = 0; i < 16; i++) cnt[i] <= '0;
        end else begin
            // Pipeline keeps tracking through clr so a held level is not recounted.
            y_q    <= Y;
            y_prev <= y_q;
            rd_cnt <= cnt[rd_sel];
            if (clr) begin
                hold    <= '0;
                last_ch <= '0;
                valid   <= 1'b0;
                err     <= 1'b0;
                for (int i = 0; i < 16; i++) cnt[i] <= '0;
            end else if (pop == 5'd1) begin
                hold    <= y_q;
                last_ch <= enc;
                valid   <= 1'b1;
                for (int i = 0; i < 16; i++) begin
                    if (rise[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end else if (pop > 5'd1) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmux_channel_capture.sv
// Randomized scoreboard bench for dmux_channel_capture with a behavioural reference model.
module tb_dmux_channel_capture;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [15:0]      Y;
    logic             clr;
    logic [3:0]       rd_sel;
    logic [15:0]      hold;
    logic [3:0]       last_ch;
    logic             valid;
    logic             err;
    logic [CNT_W-1:0] rd_cnt;

    dmux_channel_capture #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .Y(Y), .clr(clr), .rd_sel(rd_sel),
        .hold(hold), .last_ch(last_ch), .valid(valid), .err(err), .rd_cnt(rd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hold;
        logic [3:0]  last;
        logic        valid;
        logic        err;
        int          rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: the two most recent Y samples, plus the observable status.
    logic [15:0] m_s1, m_s2;
    logic [15:0] m_hold;
    logic [3:0]  m_last;
    logic        m_valid, m_err;
    int          m_cnt [16];
    int          m_rd;
    logic [15:0] cur_y;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input logic [15:0] y, input logic c, input logic [3:0] s, input logic r);
        exp_t e;
        int   ones;
        int   idx;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_hold = '0; m_last = '0;
            m_valid = 1'b0; m_err = 1'b0; m_rd = 0;
            foreach (m_cnt[k]) m_cnt[k] = 0;
        end else begin
            m_rd = m_cnt[s];
            ones = $countones(m_s1);
            idx  = 0;
            for (int k = 0; k < 16; k++) if (m_s1[k]) idx = k;
            if (c) begin
                m_hold = '0; m_last = '0; m_valid = 1'b0; m_err = 1'b0;
                foreach (m_cnt[k]) m_cnt[k] = 0;
            end else if (ones == 1) begin
                m_hold  = m_s1;
                m_last  = 4'(idx);
                m_valid = 1'b1;
                if (!m_s2[idx] && m_cnt[idx] < CMAX) m_cnt[idx]++;
            end else if (ones > 1) begin
                m_err = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = y;
        end
        e.hold = m_hold; e.last = m_last; e.valid = m_valid; e.err = m_err; e.rd = m_rd;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic [15:0] y, input logic c, input logic [3:0] s, input logic r);
        @(negedge clk);
        Y = y; clr = c; rd_sel = s; rst = r;
        cur_y = y;
        model_step(y, c, s, r);
    endtask

    // Monitor: one expected output set per clock edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("hold",    int'(hold),    int'(e.hold));
            chk("last_ch", int'(last_ch), int'(e.last));
            chk("valid",   int'(valid),   int'(e.valid));
            chk("err",     int'(err),     int'(e.err));
            chk("rd_cnt",  int'(rd_cnt),  e.rd);
        end
    end

    initial begin
        logic [15:0] ry;
        logic        rc, rr;
        int          p;
        Y = '0; clr = 1'b0; rd_sel = '0; rst = 1'b1; cur_y = '0;

        // Reset with a level already present on channel 2.
        cyc(16'h0004, 0, 4'd2, 1);
        cyc(16'h0004, 0, 4'd2, 1);
        for (int i = 0; i < 4; i++) cyc(16'h0004, 0, 4'd2, 0);
        @(negedge clk);
        chk("reset_hold", int'(hold), 16'h0004);
        chk("reset_cnt2", int'(rd_cnt), 1);

        // Level vs edge on channel 3.
        for (int i = 0; i < 10; i++) cyc(16'h0008, 0, 4'd3, 0);
        cyc(16'h0000, 0, 4'd3, 0);
        for (int i = 0; i < 3; i++) cyc(16'h0008, 0, 4'd3, 0);
        for (int i = 0; i < 4; i++) cyc(16'h0000, 0, 4'd3, 0);
        @(negedge clk);
        chk("level_cnt3", int'(rd_cnt), 2);

        // Sweep all channels, alternating with idle, then read every counter back.
        cyc(16'h0000, 1, 4'd0, 0);
        for (int s = 0; s < 16; s++) begin
            cyc(16'h0001 << s, 0, 4'(s), 0);
            cyc(16'h0000, 0, 4'(s), 0);
        end
        for (int s = 0; s < 16; s++) cyc(16'h0000, 0, 4'(s), 0);
        @(negedge clk);
        chk("sweep_last", int'(last_ch), 15);

        // Multi-hot sample sets the sticky error and leaves state alone.
        cyc(16'h0010, 0, 4'd0, 0);
        cyc(16'h0011, 0, 4'd0, 0);
        for (int i = 0; i < 3; i++) cyc(16'h0000, 0, 4'd0, 0);
        @(negedge clk);
        chk("multi_err", int'(err), 1);
        chk("multi_hold", int'(hold), 16'h0010);

        // Saturation on channel 5.
        for (int i = 0; i < 20; i++) begin
            cyc(16'h0020, 0, 4'd5, 0);
            cyc(16'h0000, 0, 4'd5, 0);
        end
        cyc(16'h0000, 0, 4'd5, 0);
        @(negedge clk);
        chk("sat_cnt5", int'(rd_cnt), CMAX);

        // Clear while channel 0 is held.
        for (int i = 0; i < 3; i++) cyc(16'h0001, 0, 4'd0, 0);
        cyc(16'h0001, 1, 4'd0, 0);
        for (int i = 0; i < 5; i++) cyc(16'h0001, 0, 4'd0, 0);
        @(negedge clk);
        chk("clr_cnt0", int'(rd_cnt), 0);
        chk("clr_valid", int'(valid), 1);
        chk("clr_err", int'(err), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            p = $urandom_range(0, 99);
            if (p < 30)      ry = '0;
            else if (p < 75) ry = 16'h0001 << $urandom_range(0, 15);
            else if (p < 85) ry = 16'($urandom);
            else             ry = cur_y;
            rc = ($urandom_range(0, 99) < 2);
            rr = ($urandom_range(0, 199) < 1);
            cyc(ry, rc, 4'($urandom_range(0, 15)), rr);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmux_channel_capture.md
# dmux_channel_capture

Downstream consumer of the 1-to-16 demultiplexer output bus. Registers the 16-bit one-hot `Y` bus, detects rising edges per channel, keeps a saturating event counter per channel, and holds the last valid one-hot pattern with its encoded index. A sticky error flag reports any multi-hot pattern. The block gives the demux stage an observable, countable sink for on-chip self-check and status readback.

## Interface
- `CNT_W`, 8: width of each per-channel event counter (saturating).
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `Y`  input  16  demux output bus; expected one-hot or all-zero; synchronous to `clk`.
- `clr`  input  1  synchronous clear of counters, hold, index, valid, err.
- `rd_sel`  input  4  channel index for counter readback.
- `hold`  output  16  last accepted one-hot pattern.
- `last_ch`  output  4  encoded index of `hold`.
- `valid`  output  1  at least one one-hot pattern accepted since reset/clear.
- `err`  output  1  sticky: a multi-hot pattern was sampled.
- `rd_cnt`  output  CNT_W  registered counter value of channel `rd_sel`.

## Operation
- Input stage: `y_q <= Y` every cycle; `y_prev <= y_q` every cycle, including during `clr`.
- `rise = y_q & ~y_prev`. `pop` is the population count of `y_q`.
- Classification of `y_q` each cycle:
  - `pop == 0`: idle; nothing updates except the pipeline registers.
  - `pop == 1`: `hold <= y_q`, `last_ch <= index(y_q)`, `valid <= 1`. If `rise[i]`, increment `cnt[i]`.
  - `pop >= 2`: `err <= 1`. `hold`, `last_ch`, `valid`, and all counters are unchanged, and rises in that cycle are discarded.
- Counters saturate at `2^CNT_W-1`; no wrap-around.
- A level held for N cycles counts once; a channel that drops to 0 and reasserts counts again.
- Channel switch i→j between consecutive cycles: `rise[j]=1` and `rise[i]=0`, so `cnt[j]` increments. `hold` and `last_ch` follow j.
- `clr` (not reset):
  - Zeroes all `cnt[i]`, `hold`, `last_ch`, `valid`, `err`.
  - Takes priority over a same-cycle update; that cycle's rise is lost.
  - `y_q`/`y_prev` keep tracking, so a level held through `clr` is not recounted.
- `rd_cnt <= cnt[rd_sel]` every cycle, using the counter value before this edge's update.
- Reset: all registers go to 0, including `y_q` and `y_prev`.
  - Outputs after reset: `hold=0`, `last_ch=0`, `valid=0`, `err=0`, `rd_cnt=0`.
  - A `Y` level already high when `rst` deasserts counts as a rise once it propagates.
  - `rst` asserted mid-operation aborts any pending update in the same cycle.

## Timing
- `Y` must be stable at rising edge E0 and is captured into `y_q` at E0.
- Classification uses `y_q` at E1. `hold`, `last_ch`, `valid`, `err`, and `cnt` are visible after E1. Latency is 2 edges from `Y`.
- `rd_cnt` reflecting that hit is visible after E2. Latency is 1 edge from an `rd_sel` change.
- Back-to-back distinct one-hot patterns on consecutive cycles are each accepted.
- No handshake; the block accepts every cycle.
- `clr` has effect at the edge where it is sampled high.

## Test plan
- **Reset:** hold `rst=1` for 2 cycles with `Y=16'h0004`, then release.
  - All outputs are 0 during reset.
  - Two edges after release: `hold=16'h0004`, `last_ch=2`, `valid=1`, `cnt[2]=1`.
- **Level vs edge:** `Y=16'h0008` for 10 cycles, 0 for 1 cycle, then `16'h0008` for 3 cycles.
  - Result: `cnt[3]=2` and `rd_cnt=2` with `rd_sel=3`.
- **Sweep:** walk `S` 0→15 through the demux with `A=1`, then `A=0`, alternating at one cycle each.
  - Every `cnt[i]=1`, `hold=16'h8000`, `last_ch=15`, `err=0`.
- **Multi-hot:** after `Y=16'h0010`, drive `Y=16'h0011` for 1 cycle.
  - Result: `err=1` (sticky), `hold=16'h0010`, `cnt[0]` unchanged.
- **Saturation:** with `CNT_W=4`, toggle channel 5 on and off 20 times.
  - Result: `cnt[5]=15`, no wrap to 0.
- **Clear:** pulse `clr` while `Y=16'h0001` is held; keep `Y` unchanged for 5 more cycles.
  - Result: `cnt[0]=0`, `err=0`.
  - `hold=16'h0001`, `valid=1` on the next cycle after `clr`, since the level re-accepts without a rise.
